// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision multiplier:
// field widths, the canonical quiet NaN, sequencer states and field helpers.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    EXP,
    MUL,
    NORM,
    DONE
  } state_e;

  function automatic logic fSign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fExp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fMant(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/expsum_bias.sv
// Signed biased-exponent sum: ea + eb - BIAS + adj, evaluated at EXP_W+2 bits
// so both overflow above the max exponent and underflow below zero are visible.
module expsum_bias #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic               [EXP_W-1:0] exp_a_i,
  input  logic               [EXP_W-1:0] exp_b_i,
  input  logic                           adj_i,
  output logic signed        [EXP_W+1:0] sum_o
);

  localparam logic [EXP_W+1:0] BIAS_V = BIAS[EXP_W+1:0];

  logic [EXP_W+1:0] rawSum;

  // Modular arithmetic at the wider width, then reinterpreted as two's complement.
  always_comb begin
    rawSum = {2'b00, exp_a_i} + {2'b00, exp_b_i} - BIAS_V + {{(EXP_W+1){1'b0}}, adj_i};
    sum_o  = $signed(rawSum);
  end

endmodule

// File: rtl/fpmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: exponent step, 24-cycle
// shift-add mantissa product, truncating normalisation, valid/ready on both sides.
module fpmul_seq #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int BIAS  = fp_pkg::BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        special
);

  import fp_pkg::*;

  localparam int MW  = MAN_W + 1;
  localparam int PW  = 2 * MW;
  localparam int CW  = $clog2(MW);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MW - 1);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((2 ** EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  state_e           state_q;
  logic [31:0]      opA_q, opB_q;
  logic [MW-1:0]    mcand_q, mplier_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    count_q;
  logic [31:0]      result_q;
  logic             ovf_q, unf_q, special_q;

  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] manA, manB;
  logic             signD, aNan, bNan, aInf, bInf, aZero, bZero;
  logic             normAdj;
  logic signed [EXP_W+1:0] expSum;
  logic [PW-1:0]    prod_d;
  logic [MAN_W-1:0] normMant;

  always_comb begin
    expA     = fExp(opA_q);
    expB     = fExp(opB_q);
    manA     = fMant(opA_q);
    manB     = fMant(opB_q);
    signD    = fSign(opA_q) ^ fSign(opB_q);
    aNan     = (expA == '1) && (manA != '0);
    bNan     = (expB == '1) && (manB != '0);
    aInf     = (expA == '1) && (manA == '0);
    bInf     = (expB == '1) && (manB == '0);
    aZero    = (expA == '0);
    bZero    = (expB == '0);
    normAdj  = (state_q == NORM) && prod_q[PW-1];
    prod_d   = prod_q + ({{MW{1'b0}}, mcand_q} << count_q);
    normMant = prod_q[PW-1] ? prod_q[PW-2 -: MAN_W] : prod_q[PW-3 -: MAN_W];
  end

  // Same adder serves the EXP step (adj=0) and the NORM step (adj=P[msb]).
  expsum_bias #(
    .EXP_W (EXP_W),
    .BIAS  (BIAS)
  ) u_expsum (
    .exp_a_i (expA),
    .exp_b_i (expB),
    .adj_i   (normAdj),
    .sum_o   (expSum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      special_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q   <= a;
            opB_q   <= b;
            state_q <= EXP;
          end
        end
        // Special operands short-circuit straight to DONE; NaN (incl. inf*0) wins.
        EXP: begin
          if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
            result_q  <= QNAN;
            special_q <= 1'b1;
            state_q   <= DONE;
          end else if (aInf || bInf) begin
            result_q  <= {signD, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            special_q <= 1'b1;
            state_q   <= DONE;
          end else if (aZero || bZero) begin
            result_q  <= {signD, {(EXP_W+MAN_W){1'b0}}};
            special_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            mcand_q  <= {1'b1, manA};
            mplier_q <= {1'b1, manB};
            prod_q   <= '0;
            count_q  <= '0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (mplier_q[0]) begin
            prod_q <= prod_d;
          end
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          if (expSum >= EXP_MAX) begin
            result_q <= {signD, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_q    <= 1'b1;
          end else if (expSum <= EXP_ZERO) begin
            result_q <= {signD, {(EXP_W+MAN_W){1'b0}}};
            unf_q    <= 1'b1;
          end else begin
            result_q <= {signD, expSum[EXP_W-1:0], normMant};
          end
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            special_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign special   = special_q;

endmodule

// File: tb/tb_fpmul_seq.sv
// Directed self-checking bench for fpmul_seq: hand-computed products, flag
// paths, handshake latency, back-pressure hold and mid-operation reset.
module tb_fpmul_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        special;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  fpmul_seq dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (aIn),
    .b         (bIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .special   (special)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair for exactly one edge; caller ensures IDLE.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    inValid = 1'b1;
    aIn     = x;
    bIn     = y;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; bounded at 100.
  task automatic waitResult(output int lat, output logic sawReady);
    lat      = 0;
    sawReady = 1'b0;
    while (outValid !== 1'b1 && lat < 100) begin
      if (inReady !== 1'b0) sawReady = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (inReady !== 1'b0) sawReady = 1'b1;
  endtask

  task automatic consume(input string tag);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, ".idleValid"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, ".idleReady"}, {31'b0, inReady}, 32'd1);
    checkOutput({tag, ".idleFlags"}, {29'b0, ovf, unf, special}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expRes, input logic [2:0] expFlags, input int expCycle);
    int   lat;
    logic sawReady;
    checkOutput({tag, ".readyBefore"}, {31'b0, inReady}, 32'd1);
    applyStimulus(x, y);
    waitResult(lat, sawReady);
    checkOutput({tag, ".cycle"}, lat + 1, expCycle);
    checkOutput({tag, ".readyLow"}, {31'b0, sawReady}, 32'd0);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".flags"}, {29'b0, ovf, unf, special}, {29'b0, expFlags});
  endtask

  initial begin
    int   lat;
    logic sawReady;
    logic stable;
    logic readyLeak;

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    aIn      = '0;
    bIn      = '0;
    #12;
    checkOutput("reset.inReady", {31'b0, inReady}, 32'd1);
    checkOutput("reset.outValid", {31'b0, outValid}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.flags", {29'b0, ovf, unf, special}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    runOp("mul2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27);
    consume("mul2x3");
    runOp("mul1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 27);
    consume("mul1p5sq");
    runOp("mulNeg", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000, 27);
    consume("mulNeg");
    runOp("overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, 27);
    consume("overflow");
    runOp("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010, 27);
    consume("underflow");
    runOp("zeroOp", 32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 3'b001, 2);
    consume("zeroOp");
    runOp("infTimesZero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, 2);
    consume("infTimesZero");

    // Back-pressure: result holds and a pending in_valid is not taken in DONE.
    runOp("hold", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27);
    inValid   = 1'b1;
    aIn       = 32'hC000_0000;
    bIn       = 32'h4040_0000;
    stable    = 1'b1;
    readyLeak = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (result !== 32'h40C0_0000 || outValid !== 1'b1) stable = 1'b0;
      if (inReady !== 1'b0) readyLeak = 1'b1;
    end
    checkOutput("hold.stable", {31'b0, stable}, 32'd1);
    checkOutput("hold.noAccept", {31'b0, readyLeak}, 32'd0);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("hold.releaseIdle", {30'b0, inReady, outValid}, 32'd2);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("hold.nextAccepted", {31'b0, inReady}, 32'd0);
    waitResult(lat, sawReady);
    checkOutput("hold.nextCycle", lat + 1, 27);
    checkOutput("hold.nextResult", result, 32'hC0C0_0000);
    consume("hold");

    // Reset in the 10th MUL cycle must abort with no output.
    applyStimulus(32'h4000_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midReset.inReady", {31'b0, inReady}, 32'd1);
    checkOutput("midReset.outValid", {31'b0, outValid}, 32'd0);
    checkOutput("midReset.result", result, 32'd0);
    checkOutput("midReset.flags", {29'b0, ovf, unf, special}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midReset.stillIdle", {31'b0, outValid}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    runOp("afterReset", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27);
    consume("afterReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
